mem_stage_lsu: RTL and testbench

MEM-stage load/store unit of the 5-stage RISC-V pipeline. It consumes the EX/MEM register contents: the ALU result is used as the address or pass-through value, and rs2 is the store data. It runs a req/ack transaction to data memory, aligns stores and extracts/extends loads. It produces the MEM/WB write-back bundle and a stall that freezes upstream stages while an access is outstanding.

---
 rtl/lsu_pkg.sv | 29 ++
 rtl/mem_stage_lsu_if.sv | 13 +
 rtl/lsu_align.sv | 58 +++++
 rtl/mem_stage_lsu.sv | 143 ++++++++++++++
 tb/tb_mem_stage_lsu.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared constants, FSM state type and the misalignment helper for the MEM-stage LSU.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {ST_IDLE, ST_ACCESS} lsu_state_t;

  localparam logic [3:0] BE_B0 = 4'b0001;
  localparam logic [3:0] BE_B1 = 4'b0010;
  localparam logic [3:0] BE_B2 = 4'b0100;
  localparam logic [3:0] BE_B3 = 4'b1000;
  localparam logic [3:0] BE_H0 = 4'b0011;
  localparam logic [3:0] BE_H1 = 4'b1100;
  localparam logic [3:0] BE_W  = 4'b1111;

  // funct3[1:0] encodes the access size; 1x (incl. undefined codes) is a word.
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lo);
    case (f3[1:0])
      2'b00:   return 1'b0;
      2'b01:   return lo[0];
      default: return lo != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Data-memory req/ack bus between the LSU (master) and data memory (slave).
interface mem_stage_lsu_if #(parameter int ADDR_W = 32);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [3:0]        be;
  logic [31:0]       wdata;
  logic              ack;
  logic [31:0]       rdata;

  modport master (output req, we, addr, be, wdata, input ack, rdata);
  modport slave  (input req, we, addr, be, wdata, output ack, rdata);
endinterface

// File: rtl/lsu_align.sv
// Combinational store lane replication / byte-enable generation and load extraction.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic        is_store,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    be    = '0;
    wdata = '0;
    if (is_store) begin
      case (funct3)
        F3_B, F3_BU: begin
          be    = BE_B0 << addr_lo;
          wdata = {4{store_data[7:0]}};
        end
        F3_H, F3_HU: begin
          be    = addr_lo[1] ? BE_H1 : BE_H0;
          wdata = {2{store_data[15:0]}};
        end
        default: begin
          be    = BE_W;
          wdata = store_data;
        end
      endcase
    end
  end

  always_comb begin
    lane_b = rdata[7:0];
    case (addr_lo)
      2'd1:    lane_b = rdata[15:8];
      2'd2:    lane_b = rdata[23:16];
      2'd3:    lane_b = rdata[31:24];
      default: lane_b = rdata[7:0];
    endcase
    lane_h = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    case (funct3)
      F3_B:    load_data = {{24{lane_b[7]}}, lane_b};
      F3_BU:   load_data = {24'b0, lane_b};
      F3_H:    load_data = {{16{lane_h[15]}}, lane_h};
      F3_HU:   load_data = {16'b0, lane_h};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: req/ack data-memory FSM, MEM/WB bundle and upstream stall.
// Optional misaligned-access trap enabled by defining LSU_MISALIGN_TRAP_EN.
module mem_stage_lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic [2:0]        ex_funct3,
  input  logic [ADDR_W-1:0] ex_alu_result,
  input  logic [DATA_W-1:0] ex_rs2_data,
  input  logic [4:0]        ex_rd,
  input  logic              ex_reg_write,
  mem_stage_lsu_if.master   dmem,
  output logic              mem_stall,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic              wb_reg_write,
  output logic [DATA_W-1:0] wb_data
`ifdef LSU_MISALIGN_TRAP_EN
  , output logic              misalign_err
  , output logic [ADDR_W-1:0] misalign_addr
`endif
);

  lsu_state_t        state, nstate;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_rs2;
  logic [2:0]        a_f3;
  logic [4:0]        a_rd;
  logic              a_rw;
  logic              a_we;
  logic              mem_op, mis, issue, in_access;
  logic [3:0]        al_be;
  logic [31:0]       al_wdata, al_load;

  assign mem_op = ex_mem_read | ex_mem_write;
`ifdef LSU_MISALIGN_TRAP_EN
  assign mis = misaligned(ex_funct3, ex_alu_result[1:0]);
`else
  assign mis = 1'b0;
`endif
  assign issue = ex_valid & mem_op & ~mis;

  always_comb begin
    nstate    = state;
    mem_stall = 1'b0;
    case (state)
      ST_IDLE: if (issue) begin
        nstate    = ST_ACCESS;
        mem_stall = 1'b1;
      end
      ST_ACCESS: if (dmem.ack) nstate = ST_IDLE;
                 else          mem_stall = 1'b1;
      default: nstate = ST_IDLE;
    endcase
    // Keep the stall low while reset is held so every output reads zero.
    if (!rst_n) mem_stall = 1'b0;
  end

  lsu_align u_align (
    .funct3     (a_f3),
    .addr_lo    (a_addr[1:0]),
    .is_store   (a_we),
    .store_data (a_rs2),
    .rdata      (dmem.rdata),
    .be         (al_be),
    .wdata      (al_wdata),
    .load_data  (al_load)
  );

  assign in_access  = (state == ST_ACCESS);
  assign dmem.req   = in_access;
  assign dmem.we    = in_access & a_we;
  assign dmem.addr  = in_access ? {a_addr[ADDR_W-1:2], 2'b00} : '0;
  assign dmem.be    = in_access ? al_be : '0;
  assign dmem.wdata = in_access ? al_wdata : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      a_addr       <= '0;
      a_rs2        <= '0;
      a_f3         <= '0;
      a_rd         <= '0;
      a_rw         <= 1'b0;
      a_we         <= 1'b0;
      wb_valid     <= 1'b0;
      wb_rd        <= '0;
      wb_reg_write <= 1'b0;
      wb_data      <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      misalign_err  <= 1'b0;
      misalign_addr <= '0;
`endif
    end else begin
      state    <= nstate;
      wb_valid <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      misalign_err <= 1'b0;
`endif
      case (state)
        ST_IDLE: if (ex_valid) begin
          if (issue) begin
            a_addr <= ex_alu_result;
            a_rs2  <= ex_rs2_data;
            a_f3   <= ex_funct3;
            a_rd   <= ex_rd;
            a_rw   <= ex_reg_write;
            a_we   <= ex_mem_write;
          end else if (mem_op) begin
            wb_valid     <= 1'b1;
            wb_rd        <= ex_rd;
            wb_reg_write <= 1'b0;
            wb_data      <= DATA_W'(ex_alu_result);
`ifdef LSU_MISALIGN_TRAP_EN
            misalign_err  <= 1'b1;
            misalign_addr <= ex_alu_result;
`endif
          end else begin
            wb_valid     <= 1'b1;
            wb_rd        <= ex_rd;
            wb_reg_write <= ex_reg_write;
            wb_data      <= DATA_W'(ex_alu_result);
          end
        end
        ST_ACCESS: if (dmem.ack) begin
          wb_valid     <= 1'b1;
          wb_rd        <= a_rd;
          wb_reg_write <= a_rw & ~a_we;
          wb_data      <= a_we ? DATA_W'(a_addr) : DATA_W'(al_load);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed table-driven bench for mem_stage_lsu plus reset and misalignment sequences.
module tb_mem_stage_lsu;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid = 1'b0, ex_mem_read = 1'b0, ex_mem_write = 1'b0;
  logic [2:0]  ex_funct3 = '0;
  logic [31:0] ex_alu_result = '0, ex_rs2_data = '0;
  logic [4:0]  ex_rd = '0;
  logic        ex_reg_write = 1'b0;
  logic        mem_stall, wb_valid, wb_reg_write;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        misalign_err;
  logic [31:0] misalign_addr;
`endif

  mem_stage_lsu_if dmem ();

  mem_stage_lsu dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ex_valid      (ex_valid),
    .ex_mem_read   (ex_mem_read),
    .ex_mem_write  (ex_mem_write),
    .ex_funct3     (ex_funct3),
    .ex_alu_result (ex_alu_result),
    .ex_rs2_data   (ex_rs2_data),
    .ex_rd         (ex_rd),
    .ex_reg_write  (ex_reg_write),
    .dmem          (dmem),
    .mem_stall     (mem_stall),
    .wb_valid      (wb_valid),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .wb_data       (wb_data)
`ifdef LSU_MISALIGN_TRAP_EN
    , .misalign_err  (misalign_err)
    , .misalign_addr (misalign_addr)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rd_en;
    logic        wr_en;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] rs2;
    logic [31:0] rdata;
    int          k;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] wb;
    logic [4:0]  rd;
    logic        rw_in;
    logic        exp_rw;
  } vec_t;

  vec_t vecs[13];

  task automatic clear_ex();
    ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
    ex_funct3 = '0; ex_alu_result = '0; ex_rs2_data = '0; ex_rd = '0; ex_reg_write = 1'b0;
  endtask

  task automatic run_op(input vec_t v);
    logic        is_mem;
    logic [31:0] waddr;
    is_mem = v.rd_en | v.wr_en;
    waddr  = v.addr;
    waddr[1:0] = 2'b00;
    ex_valid = 1'b1; ex_mem_read = v.rd_en; ex_mem_write = v.wr_en;
    ex_funct3 = v.f3; ex_alu_result = v.addr; ex_rs2_data = v.rs2;
    ex_rd = v.rd; ex_reg_write = v.rw_in;
    #1 chk("stall_accept", {31'b0, mem_stall}, {31'b0, is_mem});
    if (is_mem) begin
      for (int c = 0; c <= v.k; c++) begin
        @(posedge clk); #1;
        chk("dmem_req",   {31'b0, dmem.req}, 32'd1);
        chk("dmem_we",    {31'b0, dmem.we}, {31'b0, v.wr_en});
        chk("dmem_addr",  dmem.addr, waddr);
        chk("dmem_be",    {28'b0, dmem.be}, {28'b0, v.be});
        chk("dmem_wdata", dmem.wdata, v.wdata);
        chk("wb_valid_wait", {31'b0, wb_valid}, 32'd0);
        if (c == v.k) begin
          dmem.ack = 1'b1; dmem.rdata = v.rdata;
        end
        #1 chk("stall_access", {31'b0, mem_stall}, (c == v.k) ? 32'd0 : 32'd1);
      end
    end
    @(posedge clk); #1;
    dmem.ack = 1'b0; dmem.rdata = '0;
    clear_ex();
    chk("wb_valid",     {31'b0, wb_valid}, 32'd1);
    chk("wb_data",      wb_data, v.wb);
    chk("wb_rd",        {27'b0, wb_rd}, {27'b0, v.rd});
    chk("wb_reg_write", {31'b0, wb_reg_write}, {31'b0, v.exp_rw});
    chk("dmem_req_done", {31'b0, dmem.req}, 32'd0);
    @(posedge clk); #1;
    chk("wb_valid_pulse", {31'b0, wb_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    //          rd wr f3      addr          rs2           rdata         k  be       wdata         wb            rd   rwi  rw
    vecs[0]  = '{0, 1'b0, 3'b010, 32'h12345678, 32'h0,        32'h0,        0, 4'b0000, 32'h0,        32'h12345678, 5'd5,  1, 1};
    vecs[1]  = '{0, 1'b1, 3'b000, 32'h00001003, 32'hAABBCCDD, 32'h0,        2, 4'b1000, 32'hDDDDDDDD, 32'h00001003, 5'd7,  1, 0};
    vecs[2]  = '{1, 1'b0, 3'b000, 32'h00002001, 32'h0,        32'h00008000, 0, 4'b0000, 32'h0,        32'hFFFFFF80, 5'd8,  1, 1};
    vecs[3]  = '{1, 1'b0, 3'b100, 32'h00002001, 32'h0,        32'h00008000, 0, 4'b0000, 32'h0,        32'h00000080, 5'd9,  1, 1};
    vecs[4]  = '{1, 1'b0, 3'b001, 32'h00002002, 32'h0,        32'h80010000, 0, 4'b0000, 32'h0,        32'hFFFF8001, 5'd10, 1, 1};
    vecs[5]  = '{1, 1'b0, 3'b101, 32'h00002002, 32'h0,        32'h80010000, 0, 4'b0000, 32'h0,        32'h00008001, 5'd11, 1, 1};
    vecs[6]  = '{1, 1'b0, 3'b010, 32'h00002004, 32'h0,        32'hDEADBEEF, 1, 4'b0000, 32'h0,        32'hDEADBEEF, 5'd12, 1, 1};
    vecs[7]  = '{0, 1'b1, 3'b001, 32'h00002006, 32'h1234ABCD, 32'h0,        0, 4'b1100, 32'hABCDABCD, 32'h00002006, 5'd13, 0, 0};
    vecs[8]  = '{0, 1'b1, 3'b010, 32'h00002008, 32'hCAFEF00D, 32'h0,        1, 4'b1111, 32'hCAFEF00D, 32'h00002008, 5'd14, 0, 0};
    vecs[9]  = '{1, 1'b0, 3'b000, 32'h0000200B, 32'h0,        32'h7F000000, 0, 4'b0000, 32'h0,        32'h0000007F, 5'd15, 1, 1};
    vecs[10] = '{1, 1'b0, 3'b011, 32'h0000200C, 32'h0,        32'h11223344, 0, 4'b0000, 32'h0,        32'h11223344, 5'd16, 1, 1};
    vecs[11] = '{0, 1'b1, 3'b000, 32'h00002010, 32'h000000A5, 32'h0,        0, 4'b0001, 32'hA5A5A5A5, 32'h00002010, 5'd17, 0, 0};
    vecs[12] = '{1, 1'b0, 3'b010, 32'h00002014, 32'h0,        32'h55AA55AA, 0, 4'b0000, 32'h0,        32'h55AA55AA, 5'd18, 0, 0};

    dmem.ack = 1'b0; dmem.rdata = '0;
    ex_valid = 1'b1; ex_mem_read = 1'b1; ex_alu_result = 32'h00000100; ex_rd = 5'd3; ex_reg_write = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req",   {31'b0, dmem.req}, 32'd0);
    chk("rst_we",    {31'b0, dmem.we}, 32'd0);
    chk("rst_addr",  dmem.addr, 32'd0);
    chk("rst_be",    {28'b0, dmem.be}, 32'd0);
    chk("rst_wdata", dmem.wdata, 32'd0);
    chk("rst_stall", {31'b0, mem_stall}, 32'd0);
    chk("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
    chk("rst_wb_rd", {27'b0, wb_rd}, 32'd0);
    chk("rst_wb_rw", {31'b0, wb_reg_write}, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    clear_ex();
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_req", {31'b0, dmem.req}, 32'd0);
    chk("post_rst_wb_valid", {31'b0, wb_valid}, 32'd0);

    for (int i = 0; i < 13; i++) run_op(vecs[i]);

`ifdef LSU_MISALIGN_TRAP_EN
    ex_valid = 1'b1; ex_mem_read = 1'b1; ex_funct3 = F3_W; ex_alu_result = 32'h00003002;
    ex_rd = 5'd20; ex_reg_write = 1'b1;
    #1 chk("mis_stall", {31'b0, mem_stall}, 32'd0);
    @(posedge clk); #1;
    clear_ex();
    chk("mis_req", {31'b0, dmem.req}, 32'd0);
    chk("mis_wb_valid", {31'b0, wb_valid}, 32'd1);
    chk("mis_wb_rw", {31'b0, wb_reg_write}, 32'd0);
    chk("mis_err", {31'b0, misalign_err}, 32'd1);
    chk("mis_addr", misalign_addr, 32'h00003002);
    @(posedge clk); #1;
    chk("mis_err_pulse", {31'b0, misalign_err}, 32'd0);
    chk("mis_wb_pulse", {31'b0, wb_valid}, 32'd0);
    chk("mis_req_after", {31'b0, dmem.req}, 32'd0);
`else
    v = '{1, 1'b0, 3'b010, 32'h00003002, 32'h0, 32'h89ABCDEF, 0, 4'b0000, 32'h0, 32'h89ABCDEF, 5'd20, 1, 1};
    run_op(v);
    v = '{1, 1'b0, 3'b001, 32'h00002003, 32'h0, 32'h80010000, 0, 4'b0000, 32'h0, 32'hFFFF8001, 5'd21, 1, 1};
    run_op(v);
`endif

    ex_valid = 1'b1; ex_mem_read = 1'b1; ex_funct3 = F3_W; ex_alu_result = 32'h00004000;
    ex_rd = 5'd22; ex_reg_write = 1'b1;
    @(posedge clk); #1;
    chk("rip_req_before", {31'b0, dmem.req}, 32'd1);
    clear_ex();
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rip_req", {31'b0, dmem.req}, 32'd0);
    chk("rip_wb_valid", {31'b0, wb_valid}, 32'd0);
    chk("rip_stall", {31'b0, mem_stall}, 32'd0);
    rst_n = 1'b1;
    dmem.ack = 1'b1; dmem.rdata = 32'h0BADF00D;
    @(posedge clk); #1;
    dmem.ack = 1'b0; dmem.rdata = '0;
    chk("late_ack_wb_valid", {31'b0, wb_valid}, 32'd0);
    chk("late_ack_req", {31'b0, dmem.req}, 32'd0);
    @(posedge clk); #1;
    chk("late_ack_wb_valid2", {31'b0, wb_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
